// File: rtl/i2s_transmitter.sv
// i2s_transmitter: 16-bit stereo I2S serializer with one-pair holding register and frame-aligned shadow.
// Ports: clk_in/rst_in (sync, active-low) system clock/reset; left/right_sample_in + valid_in/ready_out
// accept a pair; i2s_bclk_out/i2s_lrclk_out/i2s_data_out serial bus; frame_start_out and underflow_out
// are 1-cycle pulses at each 64-slot frame boundary.
// Build option I2S_TX_UNDERFLOW_MUTE_EN: underflow frames are muted instead of repeating the last pair.
module i2s_transmitter #(
  parameter int BCLK_DIV = 12
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] left_sample_in,
  input  logic [15:0] right_sample_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        i2s_bclk_out,
  output logic        i2s_lrclk_out,
  output logic        i2s_data_out,
  output logic        frame_start_out,
  output logic        underflow_out
);
  localparam int DW = $clog2(BCLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [5:0] slot_q, slot_d;
  logic [31:0] hold_q, hold_d, shadow_q, shadow_d;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d, data_q, data_d;
  logic full_q, full_d, fs_q, fs_d, uf_q, uf_d;
  logic tc, fall, wrap, hs;
  logic [4:0] k;
  logic [3:0] bi;
  logic [15:0] smp;
  always_comb begin
    tc = div_q == DW'(BCLK_DIV - 1);
    fall = tc && bclk_q;
    wrap = fall && (&slot_q);
    hs = valid_in && !full_q;
    div_d = tc ? '0 : div_q + DW'(1);
    bclk_d = bclk_q ^ tc;
    slot_d = fall ? slot_q + 6'd1 : slot_q;
    lrclk_d = slot_d[5];
    k = slot_d[4:0];
    // bit 16-k expressed as ~(k-1) over 4 bits, valid for k = 1..16
    bi = k[3:0] - 4'd1;
    smp = slot_d[5] ? shadow_q[15:0] : shadow_q[31:16];
    data_d = fall ? ((k != 5'd0) && (k <= 5'd16) && smp[~bi]) : data_q;
    // a same-cycle handshake goes to the holding register, so this frame sees it as empty
    full_d = hs || (full_q && !wrap);
    hold_d = hs ? {left_sample_in, right_sample_in} : hold_q;
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
    shadow_d = wrap ? (full_q ? hold_q : '0) : shadow_q;
`else
    shadow_d = (wrap && full_q) ? hold_q : shadow_q;
`endif
    fs_d = wrap;
    uf_d = wrap && !full_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_q <= '0;
      slot_q <= '0;
      hold_q <= '0;
      shadow_q <= '0;
      bclk_q <= 1'b0;
      lrclk_q <= 1'b0;
      data_q <= 1'b0;
      full_q <= 1'b0;
      fs_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      slot_q <= slot_d;
      hold_q <= hold_d;
      shadow_q <= shadow_d;
      bclk_q <= bclk_d;
      lrclk_q <= lrclk_d;
      data_q <= data_d;
      full_q <= full_d;
      fs_q <= fs_d;
      uf_q <= uf_d;
    end
  end
  assign ready_out = !full_q;
  assign i2s_bclk_out = bclk_q;
  assign i2s_lrclk_out = lrclk_q;
  assign i2s_data_out = data_q;
  assign frame_start_out = fs_q;
  assign underflow_out = uf_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: checks i2s_transmitter at BCLK_DIV 12 and 2 against a cycle-count reference model.
module tb_i2s_transmitter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b0, valid_a = 1'b0, rst_b = 1'b0, valid_b = 1'b0;
  logic [15:0] l_a = '0, r_a = '0, l_b = '0, r_b = '0;
  logic ready_a, bclk_a, lr_a, data_a, fs_a, uf_a;
  logic ready_b, bclk_b, lr_b, data_b, fs_b, uf_b;
  int total = 0, bad = 0;
  i2s_transmitter #(.BCLK_DIV(12)) dut_a (
    .clk_in(clk), .rst_in(rst_a), .left_sample_in(l_a), .right_sample_in(r_a), .valid_in(valid_a),
    .ready_out(ready_a), .i2s_bclk_out(bclk_a), .i2s_lrclk_out(lr_a), .i2s_data_out(data_a),
    .frame_start_out(fs_a), .underflow_out(uf_a));
  i2s_transmitter #(.BCLK_DIV(2)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .left_sample_in(l_b), .right_sample_in(r_b), .valid_in(valid_b),
    .ready_out(ready_b), .i2s_bclk_out(bclk_b), .i2s_lrclk_out(lr_b), .i2s_data_out(data_b),
    .frame_start_out(fs_b), .underflow_out(uf_b));
  typedef struct packed {
    int n;
    bit full;
    logic [31:0] hold;
    logic [31:0] shadow;
    bit fs;
    bit uf;
  } mst_t;
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] exp;
  } vec_t;
  mst_t ma = '0, mb = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  // n counts clk edges since reset; BCLK toggle m happens at edge m*d, every even toggle is a fall
  function automatic mst_t step(input mst_t s, input int d, input logic rst, input logic v,
                                input logic [15:0] l, input logic [15:0] r);
    mst_t o = s;
    bit hs;
    o.fs = 1'b0;
    o.uf = 1'b0;
    if (!rst) return '0;
    hs = v && !s.full;
    o.n = s.n + 1;
    if (o.n % (128 * d) == 0) begin
      o.fs = 1'b1;
      o.uf = !s.full;
      if (s.full) begin
        o.shadow = s.hold;
        o.full = 1'b0;
      end
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
      else o.shadow = '0;
`endif
    end
    if (hs) begin
      o.hold = {l, r};
      o.full = 1'b1;
    end
    return o;
  endfunction
  function automatic int slot_of(input mst_t s, input int d);
    return (s.n / d / 2) % 64;
  endfunction
  function automatic logic [5:0] expo(input mst_t s, input int d);
    int m, slot, k;
    logic [15:0] smp;
    logic dat;
    m = s.n / d;
    slot = (m / 2) % 64;
    k = slot % 32;
    smp = slot >= 32 ? s.shadow[15:0] : s.shadow[31:16];
    dat = (k >= 1 && k <= 16) ? smp[16 - k] : 1'b0;
    return {!s.full, m[0], slot >= 32, dat, s.fs, s.uf};
  endfunction
  int cyc = 0, bra = 0, lra = 0, brb = 0, bper_a = 0, lper_a = 0, bper_b = 0;
  logic pba = 1'b0, pla = 1'b0, pbb = 1'b0;
  initial forever begin
    @(posedge clk);
    ma = step(ma, 12, rst_a, valid_a, l_a, r_a);
    mb = step(mb, 2, rst_b, valid_b, l_b, r_b);
    #1;
    cyc++;
    chk("cyc_a", {ready_a, bclk_a, lr_a, data_a, fs_a, uf_a}, expo(ma, 12));
    chk("cyc_b", {ready_b, bclk_b, lr_b, data_b, fs_b, uf_b}, expo(mb, 2));
    if (bclk_a && !pba) begin bper_a = cyc - bra; bra = cyc; end
    if (lr_a && !pla) begin lper_a = cyc - lra; lra = cyc; end
    if (bclk_b && !pbb) begin bper_b = cyc - brb; brb = cyc; end
    pba = bclk_a;
    pla = lr_a;
    pbb = bclk_b;
  end
  task automatic send(input bit w, input logic [15:0] l, input logic [15:0] r);
    int c = 0;
    logic rd;
    @(negedge clk);
    if (w) begin valid_b = 1'b1; l_b = l; r_b = r; end
    else begin valid_a = 1'b1; l_a = l; r_a = r; end
    do begin
      rd = w ? ready_b : ready_a;
      @(posedge clk);
      c++;
      if (!rd) @(negedge clk);
    end while (!rd && c < 4000);
    if (!rd) chk("send_timeout", 0, 1);
    @(negedge clk);
    if (w) valid_b = 1'b0;
    else valid_a = 1'b0;
  endtask
  task automatic capture(input bit w, output logic [63:0] bits, output logic ufs);
    int c = 0, s = 0;
    logic pb;
    bits = '0;
    ufs = 1'b0;
    do begin @(posedge clk); #1; c++; end while (!(w ? fs_b : fs_a) && c < 4000);
    if (!(w ? fs_b : fs_a)) begin chk("fs_timeout", 0, 1); return; end
    ufs = w ? uf_b : uf_a;
    pb = w ? bclk_b : bclk_a;
    c = 0;
    while (s < 64 && c < 4000) begin
      @(posedge clk); #1; c++;
      if ((w ? bclk_b : bclk_a) && !pb) begin bits[63 - s] = w ? data_b : data_a; s++; end
      pb = w ? bclk_b : bclk_a;
    end
    if (s < 64) chk("slot_timeout", 64'(s), 64);
  endtask
  task automatic wait_slot_a(input int s);
    int c = 0;
    do begin @(negedge clk); c++; end while (slot_of(ma, 12) != s && c < 4000);
    if (slot_of(ma, 12) != s) chk("slot_wait_timeout", 64'(slot_of(ma, 12)), 64'(s));
  endtask
  vec_t tbl[4];
  logic [63:0] bits, exp_uf;
  logic ufs;
  initial begin
    #950000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int c;
    tbl[0] = '{16'hA5C3, 16'h8001, 64'h52E18000_40008000};
    tbl[1] = '{16'h0000, 16'hFFFF, 64'h00000000_7FFF8000};
    tbl[2] = '{16'h1234, 16'h8000, 64'h091A0000_40000000};
    tbl[3] = '{16'h7FFF, 16'h7FFF, 64'h3FFF8000_3FFF8000};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {ready_a, bclk_a, lr_a, data_a, fs_a, uf_a}, 6'b100000);
    chk("reset_b", {ready_b, bclk_b, lr_b, data_b, fs_b, uf_b}, 6'b100000);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(0, tbl[i].l, tbl[i].r);
      capture(0, bits, ufs);
      chk($sformatf("frame_%0d", i), bits, tbl[i].exp);
      chk($sformatf("frame_uf_%0d", i), 64'(ufs), 0);
    end
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
    exp_uf = 64'h0;
`else
    exp_uf = 64'h3FFF8000_3FFF8000;
`endif
    capture(0, bits, ufs);
    chk("underflow_frame", bits, exp_uf);
    chk("underflow_pulse", 64'(ufs), 1);
    send(0, 16'h1111, 16'h2222);
    chk("b2b_ready_low", 64'(ready_a), 0);
    send(0, 16'hC3A5, 16'h0F0F);
    capture(0, bits, ufs);
    chk("b2b_second_frame", bits, 64'h61D28000_07878000);
    wait_slot_a(5);
    send(0, 16'hFFFF, 16'hFFFF);
    wait_slot_a(40);
    chk("held_ready", 64'(ready_a), 0);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset", {ready_a, bclk_a, lr_a, data_a, fs_a, uf_a}, 6'b100000);
    @(negedge clk);
    rst_a = 1'b1;
    capture(0, bits, ufs);
    chk("post_reset_frame", bits, 64'h0);
    chk("post_reset_uf", 64'(ufs), 1);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 800)) @(negedge clk);
      if ($urandom_range(0, 3) != 0) send(0, 16'($urandom), 16'($urandom));
    end
    c = 0;
    do begin @(negedge clk); c++; end while ((mb.n + 1) % 256 != 0 && c < 1000);
    valid_b = 1'b1;
    l_b = 16'hA5C3;
    r_b = 16'h8001;
    @(posedge clk);
    #1;
    chk("b_same_cycle_fs", 64'(fs_b), 1);
    chk("b_same_cycle_uf", 64'(uf_b), 1);
    chk("b_same_cycle_ready", 64'(ready_b), 0);
    @(negedge clk);
    valid_b = 1'b0;
    capture(1, bits, ufs);
    chk("b_next_frame", bits, 64'h52E18000_40008000);
    chk("b_next_uf", 64'(ufs), 0);
    chk("bclk_period_a", 64'(bper_a), 24);
    chk("lrclk_period_a", 64'(lper_a), 1536);
    chk("bclk_period_b", 64'(bper_b), 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
